// File: rtl/text_write_controller_pkg.sv
// Shared constants for the text write controller: command opcodes, FSM state
// encodings and default screen geometry.
package text_write_controller_pkg;

  localparam int TEXTCOLS_CHAR = 80;
  localparam int TEXTROWS_CHAR = 30;
  localparam int CHARATTR_W    = 16;

  typedef logic [1:0] cmdop_t;

  localparam cmdop_t CMD_PUT     = 2'b00;
  localparam cmdop_t CMD_MOVE    = 2'b01;
  localparam cmdop_t CMD_FILL    = 2'b10;
  localparam cmdop_t CMD_NEWLINE = 2'b11;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_SETUP       = 3'd1;
  localparam logic [2:0] ST_STROBE      = 3'd2;
  localparam logic [2:0] ST_FILL_SETUP  = 3'd3;
  localparam logic [2:0] ST_FILL_STROBE = 3'd4;

endpackage

// File: rtl/text_write_controller_cursor.sv
// Row-major (x,y) position register with clear, load, newline and advance;
// wraps at the last column and last row.
module text_cursor
  import text_write_controller_pkg::*;
#(
  parameter int COLS  = TEXTCOLS_CHAR,
  parameter int ROWS  = TEXTROWS_CHAR,
  parameter int COL_W = $clog2(COLS),
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [COL_W-1:0] load_x_i,
  input  logic [ROW_W-1:0] load_y_i,
  input  logic             nl_i,
  input  logic             adv_i,
  output logic [COL_W-1:0] x_o,
  output logic [ROW_W-1:0] y_o,
  output logic [COL_W-1:0] nx_o,
  output logic [ROW_W-1:0] ny_o,
  output logic             last_o
);

  localparam logic [COL_W-1:0] X_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(ROWS - 1);

  logic [COL_W-1:0] x_q, x_d;
  logic [ROW_W-1:0] y_q, y_d;
  logic [ROW_W-1:0] y_inc;

  assign y_inc  = (y_q == Y_MAX) ? '0 : y_q + ROW_W'(1);
  assign nx_o   = (x_q == X_MAX) ? '0 : x_q + COL_W'(1);
  assign ny_o   = (x_q == X_MAX) ? y_inc : y_q;
  assign last_o = (x_q == X_MAX) && (y_q == Y_MAX);
  assign x_o    = x_q;
  assign y_o    = y_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (load_i) begin
      x_d = load_x_i;
      y_d = load_y_i;
    end else if (nl_i) begin
      x_d = '0;
      y_d = y_inc;
    end else if (adv_i) begin
      x_d = nx_o;
      y_d = ny_o;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/text_write_controller.sv
// Sequences host commands into single-cycle write strobes for the text video
// memory, keeping address/data stable for a full cycle before each strobe.
//
// state          | meaning
// ST_IDLE        | ready; MOVE/NEWLINE execute here at the accept edge
// ST_SETUP       | PUT address/data driven, strobe low
// ST_STROBE      | PUT strobe high; cursor advances on exit
// ST_FILL_SETUP  | fill cell address/data driven, strobe low
// ST_FILL_STROBE | fill strobe high; step to next cell or finish
module text_write_controller
  import text_write_controller_pkg::*;
#(
  parameter int COLS   = TEXTCOLS_CHAR,
  parameter int ROWS   = TEXTROWS_CHAR,
  parameter int COL_W  = $clog2(COLS),
  parameter int ROW_W  = $clog2(ROWS),
  parameter int ATTR_W = CHARATTR_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [COL_W-1:0]  cmd_x_i,
  input  logic [ROW_W-1:0]  cmd_y_i,
  input  logic [ATTR_W-1:0] cmd_value_i,
  output logic              write_o,
  output logic [COL_W-1:0]  xtextwrite_o,
  output logic [ROW_W-1:0]  ytextwrite_o,
  output logic [ATTR_W-1:0] value_o,
  output logic [COL_W-1:0]  cursor_x_o,
  output logic [ROW_W-1:0]  cursor_y_o,
  output logic              busy_o
);

  localparam logic [COL_W-1:0] X_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(ROWS - 1);

  logic [2:0]        state_q, state_d;
  logic              write_q, write_d;
  logic [COL_W-1:0]  xw_q, xw_d;
  logic [ROW_W-1:0]  yw_q, yw_d;
  logic [ATTR_W-1:0] val_q, val_d;
  logic              ready_q, busy_q;

  logic             accept;
  logic             cur_load, cur_nl, cur_adv, cur_clr;
  logic             fill_clr, fill_adv;
  logic [COL_W-1:0] cur_x, cur_nx, fill_x, fill_nx, move_x;
  logic [ROW_W-1:0] cur_y, cur_ny, fill_y, fill_ny, move_y;
  logic             cur_last, fill_last;
  logic             unused_ok;

  assign accept = cmd_valid_i & ready_q;
  assign move_x = (cmd_x_i > X_MAX) ? X_MAX : cmd_x_i;
  assign move_y = (cmd_y_i > Y_MAX) ? Y_MAX : cmd_y_i;
  assign unused_ok = ^{cur_nx, cur_ny, cur_last, fill_x, fill_y};

  text_cursor #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)) u_cursor (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (cur_clr),
    .load_i   (cur_load),
    .load_x_i (move_x),
    .load_y_i (move_y),
    .nl_i     (cur_nl),
    .adv_i    (cur_adv),
    .x_o      (cur_x),
    .y_o      (cur_y),
    .nx_o     (cur_nx),
    .ny_o     (cur_ny),
    .last_o   (cur_last)
  );

  // Fill index: only ever cleared and advanced, never loaded.
  text_cursor #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W)) u_fill (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (fill_clr),
    .load_i   (1'b0),
    .load_x_i ('0),
    .load_y_i ('0),
    .nl_i     (1'b0),
    .adv_i    (fill_adv),
    .x_o      (fill_x),
    .y_o      (fill_y),
    .nx_o     (fill_nx),
    .ny_o     (fill_ny),
    .last_o   (fill_last)
  );

  always_comb begin
    state_d  = state_q;
    write_d  = 1'b0;
    xw_d     = xw_q;
    yw_d     = yw_q;
    val_d    = val_q;
    cur_load = 1'b0;
    cur_nl   = 1'b0;
    cur_adv  = 1'b0;
    cur_clr  = 1'b0;
    fill_clr = 1'b0;
    fill_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op_i)
            CMD_PUT: begin
              xw_d    = cur_x;
              yw_d    = cur_y;
              val_d   = cmd_value_i;
              state_d = ST_SETUP;
            end
            CMD_MOVE:    cur_load = 1'b1;
            CMD_NEWLINE: cur_nl   = 1'b1;
            CMD_FILL: begin
              fill_clr = 1'b1;
              xw_d     = '0;
              yw_d     = '0;
              val_d    = cmd_value_i;
              state_d  = ST_FILL_SETUP;
            end
            default: ;
          endcase
        end
      end
      ST_SETUP: begin
        write_d = 1'b1;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        cur_adv = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FILL_SETUP: begin
        write_d = 1'b1;
        state_d = ST_FILL_STROBE;
      end
      ST_FILL_STROBE: begin
        if (fill_last) begin
          cur_clr = 1'b1;
          state_d = ST_IDLE;
        end else begin
          fill_adv = 1'b1;
          xw_d     = fill_nx;
          yw_d     = fill_ny;
          state_d  = ST_FILL_SETUP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      xw_q    <= '0;
      yw_q    <= '0;
      val_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      xw_q    <= xw_d;
      yw_q    <= yw_d;
      val_q   <= val_d;
      ready_q <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign cmd_ready_o  = ready_q;
  assign busy_o       = busy_q;
  assign write_o      = write_q;
  assign xtextwrite_o = xw_q;
  assign ytextwrite_o = yw_q;
  assign value_o      = val_q;
  assign cursor_x_o   = cur_x;
  assign cursor_y_o   = cur_y;

endmodule

// File: tb/tb_text_write_controller.sv
// Directed and model-checked bench for text_write_controller on a 4x3 screen.
module tb_text_write_controller;

  localparam int COLS   = 4;
  localparam int ROWS   = 3;
  localparam int COL_W  = 2;
  localparam int ROW_W  = 2;
  localparam int ATTR_W = 16;

  localparam logic [1:0] OP_PUT  = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_FILL = 2'b10;
  localparam logic [1:0] OP_NL   = 2'b11;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready_o;
  logic [1:0]        cmd_op = 2'b00;
  logic [COL_W-1:0]  cmd_x = '0;
  logic [ROW_W-1:0]  cmd_y = '0;
  logic [ATTR_W-1:0] cmd_value = '0;
  logic              write_o;
  logic [COL_W-1:0]  xtextwrite_o;
  logic [ROW_W-1:0]  ytextwrite_o;
  logic [ATTR_W-1:0] value_o;
  logic [COL_W-1:0]  cursor_x_o;
  logic [ROW_W-1:0]  cursor_y_o;
  logic              busy_o;

  int checks = 0;
  int failures = 0;

  text_write_controller #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .ATTR_W(ATTR_W)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op),
    .cmd_x_i      (cmd_x),
    .cmd_y_i      (cmd_y),
    .cmd_value_i  (cmd_value),
    .write_o      (write_o),
    .xtextwrite_o (xtextwrite_o),
    .ytextwrite_o (ytextwrite_o),
    .value_o      (value_o),
    .cursor_x_o   (cursor_x_o),
    .cursor_y_o   (cursor_y_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Shadow of the video memory, latched on the strobe's rising edge.
  logic [ATTR_W-1:0] shadow [0:ROWS-1][0:COLS-1];
  int pulse_cnt = 0;
  int px[$], py[$], pv[$];
  int hi_run = 0, max_hi_run = 0;

  initial begin
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        shadow[r][c] = '0;
  end

  always @(posedge write_o) begin
    if (int'(ytextwrite_o) < ROWS) shadow[ytextwrite_o][xtextwrite_o] = value_o;
    px.push_back(int'(xtextwrite_o));
    py.push_back(int'(ytextwrite_o));
    pv.push_back(int'(value_o));
    pulse_cnt++;
  end

  always @(negedge clk) begin
    if (write_o) begin
      hi_run++;
      if (hi_run > max_hi_run) max_hi_run = hi_run;
    end else begin
      hi_run = 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_cursor(input string tag, input int ex, input int ey);
    check_val({tag, "_x"}, 32'(cursor_x_o), 32'(ex));
    check_val({tag, "_y"}, 32'(cursor_y_o), 32'(ey));
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic [1:0] op, input int x, input int y, input int v);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = x[COL_W-1:0];
    cmd_y     = y[ROW_W-1:0];
    cmd_value = v[ATTR_W-1:0];
    while (!cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("send_ready", 32'(cmd_ready_o), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_wait", 32'(cmd_ready_o), 32'd1);
  endtask

  int mcx, mcy;
  logic [ATTR_W-1:0] exp_mem [0:ROWS-1][0:COLS-1];

  task automatic model_adv();
    if (mcx < COLS - 1) mcx++;
    else begin
      mcx = 0;
      mcy = (mcy == ROWS - 1) ? 0 : mcy + 1;
    end
  endtask

  initial begin
    int pre, cnt, r, x, y, v;

    repeat (2) @(negedge clk);
    check_val("rst_ready", 32'(cmd_ready_o), 32'd1);
    check_val("rst_write", 32'(write_o), 32'd0);
    check_val("rst_xw", 32'(xtextwrite_o), 32'd0);
    check_val("rst_yw", 32'(ytextwrite_o), 32'd0);
    check_val("rst_value", 32'(value_o), 32'd0);
    check_val("rst_busy", 32'(busy_o), 32'd0);
    check_cursor("rst_cur", 0, 0);
    reset = 1'b0;
    @(negedge clk);

    // PUT timing, cycle by cycle
    pre = pulse_cnt;
    cmd_valid = 1'b1; cmd_op = OP_PUT; cmd_value = 16'h041;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_val("put_setup_write", 32'(write_o), 32'd0);
    check_val("put_setup_ready", 32'(cmd_ready_o), 32'd0);
    check_val("put_setup_busy", 32'(busy_o), 32'd1);
    check_val("put_setup_xw", 32'(xtextwrite_o), 32'd0);
    check_val("put_setup_yw", 32'(ytextwrite_o), 32'd0);
    check_val("put_setup_val", 32'(value_o), 32'h041);
    @(negedge clk);
    check_val("put_strobe_write", 32'(write_o), 32'd1);
    check_val("put_strobe_val", 32'(value_o), 32'h041);
    check_val("put_strobe_ready", 32'(cmd_ready_o), 32'd0);
    @(negedge clk);
    check_val("put_done_write", 32'(write_o), 32'd0);
    check_val("put_done_ready", 32'(cmd_ready_o), 32'd1);
    check_val("put_done_busy", 32'(busy_o), 32'd0);
    check_cursor("put_done_cur", 1, 0);
    check_val("put_pulses", 32'(pulse_cnt - pre), 32'd1);
    check_val("put_mem00", 32'(shadow[0][0]), 32'h041);

    // MOVE, PUT at last cell wraps, MOVE clamps
    send(OP_MOVE, 3, 2, 0);
    check_cursor("move32", 3, 2);
    send(OP_PUT, 0, 0, 16'h042);
    wait_idle();
    check_val("put_mem32", 32'(shadow[2][3]), 32'h042);
    check_cursor("put_wrap", 0, 0);
    send(OP_MOVE, 3, 3, 0);
    check_cursor("move_clamp", 3, 2);
    send(OP_MOVE, 1, 3, 0);
    check_cursor("move_clamp_y", 1, 2);

    // NEWLINE
    send(OP_MOVE, 2, 2, 0);
    pre = pulse_cnt;
    send(OP_NL, 0, 0, 0);
    check_cursor("nl_wrap", 0, 0);
    send(OP_NL, 0, 0, 0);
    check_cursor("nl_next", 0, 1);
    check_val("nl_no_write", 32'(pulse_cnt - pre), 32'd0);

    // FILL with a pending MOVE held valid throughout
    pre = pulse_cnt;
    px.delete(); py.delete(); pv.delete();
    cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_value = 16'h020;
    @(negedge clk);
    cmd_op = OP_MOVE; cmd_x = 2'd1; cmd_y = 2'd1; cmd_value = 16'h3ff;
    cnt = 0;
    while (busy_o && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check_val("fill_busy_cycles", 32'(cnt), 32'd24);
    check_val("fill_ready", 32'(cmd_ready_o), 32'd1);
    check_cursor("fill_cur", 0, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_cursor("fill_then_move", 1, 1);
    check_val("fill_pulses", 32'(pulse_cnt - pre), 32'd12);
    for (int i = 0; i < COLS * ROWS; i++) begin
      check_val($sformatf("fill_x%0d", i), 32'(px[i]), 32'(i % COLS));
      check_val($sformatf("fill_y%0d", i), 32'(py[i]), 32'(i / COLS));
      check_val($sformatf("fill_v%0d", i), 32'(pv[i]), 32'h020);
    end

    // Reset during FILL while the 5th strobe is high
    send(OP_FILL, 0, 0, 16'h155);
    pre = pulse_cnt - 1 + 1;
    pre = pre - 0;
    cnt = 0;
    while ((pulse_cnt - pre) < 5 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check_val("abort_reached5", 32'(pulse_cnt - pre), 32'd5);
    check_val("abort_strobe_hi", 32'(write_o), 32'd1);
    reset = 1'b1;
    #1;
    check_val("abort_write_drop", 32'(write_o), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check_val("abort_pulses", 32'(pulse_cnt - pre), 32'd5);
    check_cursor("abort_cur", 0, 0);
    check_val("abort_ready", 32'(cmd_ready_o), 32'd1);
    check_val("abort_busy", 32'(busy_o), 32'd0);
    check_val("abort_cell4", 32'(shadow[1][0]), 32'h155);
    check_val("abort_cell5", 32'(shadow[1][1]), 32'h020);

    // Random command mix against a reference model
    for (int i = 0; i < COLS * ROWS; i++)
      exp_mem[i / COLS][i % COLS] = (i < 5) ? 16'h155 : 16'h020;
    mcx = 0; mcy = 0;
    for (int k = 0; k < 50; k++) begin
      r = $urandom_range(0, 9);
      x = $urandom_range(0, 3);
      y = $urandom_range(0, 3);
      v = $urandom_range(0, 16'hffff);
      if (r <= 5) begin
        send(OP_PUT, x, y, v);
        exp_mem[mcy][mcx] = v[ATTR_W-1:0];
        model_adv();
      end else if (r <= 7) begin
        send(OP_MOVE, x, y, v);
        mcx = (x > COLS - 1) ? COLS - 1 : x;
        mcy = (y > ROWS - 1) ? ROWS - 1 : y;
      end else if (r == 8) begin
        send(OP_NL, x, y, v);
        mcx = 0;
        mcy = (mcy == ROWS - 1) ? 0 : mcy + 1;
      end else begin
        send(OP_FILL, x, y, v);
        for (int j = 0; j < COLS * ROWS; j++) exp_mem[j / COLS][j % COLS] = v[ATTR_W-1:0];
        mcx = 0; mcy = 0;
      end
      wait_idle();
      check_cursor($sformatf("rand%0d_cur", k), mcx, mcy);
    end
    for (int j = 0; j < COLS * ROWS; j++)
      check_val($sformatf("screen_%0d", j), 32'(shadow[j / COLS][j % COLS]), 32'(exp_mem[j / COLS][j % COLS]));
    check_val("strobe_width", 32'(max_hi_run), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
